// File: rtl/datapath_pkg.sv
`default_nettype none
// ==========================================================================
// datapath_pkg : ALU opcodes, operand/destination codes, control-word fields
// Rev 1.0
// ==========================================================================
package datapath_pkg;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_SHL  = 3'b110;
  localparam logic [2:0] ALU_SHR  = 3'b111;

  localparam logic [3:0] SRC_R0   = 4'd0;
  localparam logic [3:0] SRC_R1   = 4'd1;
  localparam logic [3:0] SRC_R2   = 4'd2;
  localparam logic [3:0] SRC_R3   = 4'd3;
  localparam logic [3:0] SRC_R4   = 4'd4;
  localparam logic [3:0] SRC_R5   = 4'd5;
  localparam logic [3:0] SRC_R6   = 4'd6;
  localparam logic [3:0] SRC_R7   = 4'd7;
  localparam logic [3:0] SRC_IN   = 4'd8;
  localparam logic [3:0] SRC_ZERO = 4'd9;
  localparam logic [3:0] SRC_ONE  = 4'd10;

  localparam logic [3:0] DST_OUT  = 4'd8;

  localparam int CW_ALU_HI = 15;
  localparam int CW_ALU_LO = 13;
  localparam int CW_A_HI   = 12;
  localparam int CW_A_LO   = 9;
  localparam int CW_B_HI   = 8;
  localparam int CW_B_LO   = 5;
  localparam int CW_DST_HI = 4;
  localparam int CW_DST_LO = 1;
  localparam int CW_W      = 0;

endpackage
`default_nettype wire

// File: rtl/datapath_exec_alu.sv
`default_nettype none
// ==========================================================================
// alu : combinational unsigned ALU with zero detect, results modulo 2^WIDTH
// Rev 1.0
// ==========================================================================
module alu
  import datapath_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  always_comb begin
    y = '0;
    case (op)
      ALU_PASS: y = a;
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SHL:  y = a << 1;
      ALU_SHR:  y = a >> 1;
      default:  y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule
`default_nettype wire

// File: rtl/datapath_exec.sv
`default_nettype none
// ==========================================================================
// datapath_exec : executes the FSM control word; register file, muxes, ALU, flags
// Rev 1.0
// ==========================================================================
module datapath_exec
  import datapath_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      i_ctrl,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_result,
  output logic             o_valid,
  output logic             o_mayor,
  output logic             o_bandera
);

  logic [2:0]             w_op;
  logic [3:0]             w_sel_a;
  logic [3:0]             w_sel_b;
  logic [3:0]             w_dst;
  logic                   w_we;
  logic [WIDTH-1:0]       w_a;
  logic [WIDTH-1:0]       w_b;
  logic [WIDTH-1:0]       w_y;
  logic                   w_zero;

  logic [7:0][WIDTH-1:0]  r_regs;
  logic [WIDTH-1:0]       r_result;
  logic                   r_valid;
  logic                   r_mayor;
  logic                   r_bandera;

  assign w_op    = i_ctrl[CW_ALU_HI:CW_ALU_LO];
  assign w_sel_a = i_ctrl[CW_A_HI:CW_A_LO];
  assign w_sel_b = i_ctrl[CW_B_HI:CW_B_LO];
  assign w_dst   = i_ctrl[CW_DST_HI:CW_DST_LO];
  assign w_we    = i_ctrl[CW_W];

  // Codes 9 and 11-15 fall through to constant zero
  always_comb begin
    w_a = '0;
    if (w_sel_a <= SRC_R7)        w_a = r_regs[w_sel_a[2:0]];
    else if (w_sel_a == SRC_IN)   w_a = i_data;
    else if (w_sel_a == SRC_ONE)  w_a = WIDTH'(1);
    else if (w_sel_a == SRC_ZERO) w_a = '0;
  end

  always_comb begin
    w_b = '0;
    if (w_sel_b <= SRC_R7)        w_b = r_regs[w_sel_b[2:0]];
    else if (w_sel_b == SRC_IN)   w_b = i_data;
    else if (w_sel_b == SRC_ONE)  w_b = WIDTH'(1);
    else if (w_sel_b == SRC_ZERO) w_b = '0;
  end

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a    (w_a),
    .b    (w_b),
    .op   (w_op),
    .y    (w_y),
    .zero (w_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regs    <= '0;
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_mayor   <= 1'b0;
      r_bandera <= 1'b0;
    end else begin
      if (w_we && (w_dst <= 4'd7)) r_regs[w_dst[2:0]] <= w_y;
      if (w_we && (w_dst == DST_OUT)) r_result <= w_y;
      r_valid   <= w_we && (w_dst == DST_OUT);
      // Flags track every word, written or not, one cycle behind
      r_mayor   <= (w_a > w_b);
      r_bandera <= w_zero;
    end
  end

  assign o_result  = r_result;
  assign o_valid   = r_valid;
  assign o_mayor   = r_mayor;
  assign o_bandera = r_bandera;

endmodule
`default_nettype wire

// File: tb/tb_datapath_exec.sv
`default_nettype none
// ==========================================================================
// tb_datapath_exec : directed stimulus against a behavioural datapath model
// Rev 1.0
// ==========================================================================
module tb_datapath_exec;

  logic        clk;
  logic        rst;
  logic [15:0] i_ctrl;
  logic [7:0]  i_data;
  logic [7:0]  o_result;
  logic        o_valid;
  logic        o_mayor;
  logic        o_bandera;

  int checks = 0;
  int fails  = 0;

  datapath_exec #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_ctrl    (i_ctrl),
    .i_data    (i_data),
    .o_result  (o_result),
    .o_valid   (o_valid),
    .o_mayor   (o_mayor),
    .o_bandera (o_bandera)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] cw(input int op, input int a, input int b,
                                     input int dst, input int w);
    logic [15:0] v;
    v = {op[2:0], a[3:0], b[3:0], dst[3:0], w[0]};
    return v;
  endfunction

  // Behavioural model: integer arithmetic on an 8-entry array
  int m_regs [8];
  int m_result, m_valid, m_mayor, m_band;
  int mo, ma, mb, md, mw, my;

  function automatic int src(input int code, input int ext);
    if (code < 8)   return m_regs[code];
    if (code == 8)  return ext;
    if (code == 10) return 1;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
      m_result = 0; m_valid = 0; m_mayor = 0; m_band = 0;
    end else begin
      mo = int'(i_ctrl[15:13]);
      ma = src(int'(i_ctrl[12:9]), int'(i_data));
      mb = src(int'(i_ctrl[8:5]), int'(i_data));
      md = int'(i_ctrl[4:1]);
      mw = int'(i_ctrl[0]);
      case (mo)
        0: my = ma;
        1: my = (ma + mb) % 256;
        2: my = (ma - mb + 256) % 256;
        3: my = ma & mb;
        4: my = ma | mb;
        5: my = ma ^ mb;
        6: my = (ma * 2) % 256;
        default: my = ma / 2;
      endcase
      m_mayor = (ma > mb) ? 1 : 0;
      m_band  = (my == 0) ? 1 : 0;
      m_valid = (mw == 1 && md == 8) ? 1 : 0;
      if (mw == 1 && md < 8)  m_regs[md] = my;
      if (mw == 1 && md == 8) m_result = my;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_result",  int'(o_result),  m_result);
      chk("model_valid",   int'(o_valid),   m_valid);
      chk("model_mayor",   int'(o_mayor),   m_mayor);
      chk("model_bandera", int'(o_bandera), m_band);
    end
  end

  task automatic apply(input logic [15:0] c, input logic [7:0] d);
    @(negedge clk);
    i_ctrl = c;
    i_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int r, input int v);
    apply(cw(0, 8, 0, r, 1), v[7:0]);
  endtask

  initial begin
    rst    = 1'b1;
    i_ctrl = '0;
    i_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_result", int'(o_result), 0);
    chk("reset_flags",  int'({o_valid, o_mayor, o_bandera}), 0);

    // Mid-run asynchronous reset
    load(3, 8'h55);
    apply(cw(0, 3, 0, 8, 1), 8'h00);
    chk("r3_before_rst", int'(o_result), 8'h55);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_result", int'(o_result), 0);
    chk("async_rst_valid",  int'(o_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    apply(cw(0, 3, 0, 8, 1), 8'h00);
    chk("r3_after_rst", int'(o_result), 0);
    chk("r3_after_rst_valid", int'(o_valid), 1);

    // i_data through R2 to o_result, single valid pulse
    load(2, 8'h0F);
    apply(cw(0, 2, 0, 8, 1), 8'h00);
    chk("out_0f", int'(o_result), 8'h0F);
    chk("valid_pulse", int'(o_valid), 1);
    apply(16'h0000, 8'h00);
    chk("valid_drop", int'(o_valid), 0);
    chk("idle_bandera", int'(o_bandera), 1);
    chk("idle_mayor", int'(o_mayor), 0);

    // Wrapping add drives zero flag
    load(1, 8'hFF);
    load(2, 8'h01);
    apply(cw(1, 1, 2, 3, 1), 8'h00);
    chk("add_wrap_zero", int'(o_bandera), 1);
    apply(cw(0, 3, 0, 8, 1), 8'h00);
    chk("add_wrap_r3", int'(o_result), 0);

    // Unsigned compare
    load(1, 8'h05);
    load(2, 8'h09);
    apply(cw(0, 1, 2, 9, 1), 8'h00);
    chk("mayor_5_9", int'(o_mayor), 0);
    apply(cw(0, 2, 1, 9, 1), 8'h00);
    chk("mayor_9_5", int'(o_mayor), 1);
    apply(cw(0, 1, 1, 12, 1), 8'h00);
    chk("mayor_eq", int'(o_mayor), 0);

    // Shifts and borrow
    load(4, 8'h81);
    apply(cw(6, 4, 0, 8, 1), 8'h00);
    chk("shl_81", int'(o_result), 8'h02);
    apply(cw(7, 4, 0, 8, 1), 8'h00);
    chk("shr_81", int'(o_result), 8'h40);
    chk("b2b_valid", int'(o_valid), 1);
    apply(cw(2, 9, 10, 8, 1), 8'h00);
    chk("sub_0_1", int'(o_result), 8'hFF);

    // Every op with R1=0x05, R2=0x09, checked by the model
    for (int op = 0; op < 8; op++) apply(cw(op, 1, 2, 8, 1), 8'h00);
    // Same codes with i_data and unused mux codes
    for (int op = 0; op < 8; op++) apply(cw(op, 8, 13 - op, 8, 1), 8'hA6);

    // Write suppression
    load(3, 8'h33);
    apply(cw(0, 8, 0, 3, 0), 8'hAA);
    apply(cw(0, 3, 0, 8, 1), 8'h00);
    chk("w0_keeps_r3", int'(o_result), 8'h33);
    apply(cw(0, 8, 0, 12, 1), 8'hEE);
    chk("dst12_no_out", int'(o_result), 8'h33);
    chk("dst12_no_valid", int'(o_valid), 0);
    apply(cw(0, 8, 0, 8, 0), 8'h77);
    chk("w0_dst8_result", int'(o_result), 8'h33);
    chk("w0_dst8_valid", int'(o_valid), 0);
    apply(cw(0, 3, 0, 8, 1), 8'h00);
    chk("r3_intact", int'(o_result), 8'h33);

    // Read and write R5 in one cycle
    load(5, 8'h10);
    apply(cw(1, 5, 10, 5, 1), 8'h00);
    apply(cw(1, 5, 5, 8, 1), 8'h00);
    chk("r5_rw_old", int'(o_result), 8'h22);

    apply(16'h0000, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
